aha_code_region_arbiter: RTL

AHA_CODE_REGION_ARBITER -- requirements
Module: AhaCodeRegionArbiter

---
 rtl/aha_code_region_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/aha_code_region_arbiter.sv
// Two-master arbiter for the code-region SRAM: M0 (CPU I/D) has fixed priority,
// M1 (loader/debug) is protected from starvation by a saturating counter.
module aha_code_region_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        M0_HSEL,
  input  logic        M1_HSEL,
  input  logic        M0_HREADY,
  input  logic        M1_HREADY,
  input  logic [1:0]  M0_HTRANS,
  input  logic [1:0]  M1_HTRANS,
  input  logic [31:0] M0_HADDR,
  input  logic [31:0] M1_HADDR,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M1_HSIZE,
  input  logic        M0_HWRITE,
  input  logic        M1_HWRITE,
  input  logic [31:0] M0_HWDATA,
  input  logic [31:0] M1_HWDATA,
  output logic        M0_HREADYOUT,
  output logic        M1_HREADYOUT,
  output logic [1:0]  M0_HRESP,
  output logic [1:0]  M1_HRESP,
  output logic [31:0] M0_HRDATA,
  output logic [31:0] M1_HRDATA,
  output logic        S_HSEL,
  output logic [1:0]  S_HTRANS,
  output logic [31:0] S_HADDR,
  output logic [2:0]  S_HSIZE,
  output logic        S_HWRITE,
  output logic [31:0] S_HWDATA,
  input  logic        S_HREADYOUT,
  input  logic [1:0]  S_HRESP,
  input  logic [31:0] S_HRDATA,
  output logic [1:0]  DPHASE_OWNER
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M0   = 2'b01;
  localparam logic [1:0] OWN_M1   = 2'b10;

  logic        r_pend0, r_pend1;
  logic [31:0] r_addr0, r_addr1;
  logic [2:0]  r_size0, r_size1;
  logic        r_wr0, r_wr1;
  logic [3:0]  r_starve;
  logic [1:0]  r_owner;

  logic w_val0, w_val1;
  logic w_req0, w_req1;
  logic w_gnt0, w_gnt1;
  logic w_slot;

  assign w_val0 = M0_HSEL & M0_HTRANS[1] & M0_HREADY;
  assign w_val1 = M1_HSEL & M1_HTRANS[1] & M1_HREADY;
  assign w_req0 = r_pend0 | w_val0;
  assign w_req1 = r_pend1 | w_val1;

  // Reset gates the slot so nothing is issued while HRESETn is low
  assign w_slot = S_HREADYOUT & HRESETn;
  assign w_gnt1 = w_slot & w_req1 & (~w_req0 | (r_starve == LIM));
  assign w_gnt0 = w_slot & w_req0 & ~w_gnt1;

  assign S_HSEL   = w_gnt0 | w_gnt1;
  assign S_HTRANS = (w_gnt0 | w_gnt1) ? 2'b10 : 2'b00;

  always_comb begin
    S_HADDR  = r_pend0 ? r_addr0 : M0_HADDR;
    S_HSIZE  = r_pend0 ? r_size0 : M0_HSIZE;
    S_HWRITE = r_pend0 ? r_wr0   : M0_HWRITE;
    if (w_gnt1) begin
      S_HADDR  = r_pend1 ? r_addr1 : M1_HADDR;
      S_HSIZE  = r_pend1 ? r_size1 : M1_HSIZE;
      S_HWRITE = r_pend1 ? r_wr1   : M1_HWRITE;
    end
  end

  assign S_HWDATA = (r_owner == OWN_M1) ? M1_HWDATA : M0_HWDATA;

  assign M0_HREADYOUT = (r_owner == OWN_M0) ? S_HREADYOUT : ~r_pend0;
  assign M1_HREADYOUT = (r_owner == OWN_M1) ? S_HREADYOUT : ~r_pend1;
  assign M0_HRESP     = (r_owner == OWN_M0) ? S_HRESP : 2'b00;
  assign M1_HRESP     = (r_owner == OWN_M1) ? S_HRESP : 2'b00;
  assign M0_HRDATA    = S_HRDATA;
  assign M1_HRDATA    = S_HRDATA;
  assign DPHASE_OWNER = r_owner;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pend0 <= 1'b0;
      r_addr0 <= '0;
      r_size0 <= '0;
      r_wr0   <= 1'b0;
    end else if (w_gnt0) begin
      r_pend0 <= 1'b0;
    end else if (w_val0 && !r_pend0) begin
      r_pend0 <= 1'b1;
      r_addr0 <= M0_HADDR;
      r_size0 <= M0_HSIZE;
      r_wr0   <= M0_HWRITE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pend1 <= 1'b0;
      r_addr1 <= '0;
      r_size1 <= '0;
      r_wr1   <= 1'b0;
    end else if (w_gnt1) begin
      r_pend1 <= 1'b0;
    end else if (w_val1 && !r_pend1) begin
      r_pend1 <= 1'b1;
      r_addr1 <= M1_HADDR;
      r_size1 <= M1_HSIZE;
      r_wr1   <= M1_HWRITE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_starve <= '0;
    end else if (w_gnt1 || !w_req1) begin
      r_starve <= '0;
    end else if (w_gnt0 && r_starve != LIM) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_owner <= OWN_NONE;
    end else if (S_HREADYOUT) begin
      unique case (1'b1)
        w_gnt1:  r_owner <= OWN_M1;
        w_gnt0:  r_owner <= OWN_M0;
        default: r_owner <= OWN_NONE;
      endcase
    end
  end

endmodule
